// File: rtl/state_transitions.sv
// -----------------------------------------------------------------------------
// state_transitions
//   Vending-machine controller: goods selection, coin payment, change and
//   refund, plus an 8-digit multiplexed seven-segment display of the amounts.
//
// Parameters
//   SCAN_DIV      sys_clk cycles each display digit is held (default 100000).
//
// Build option
//   CHANGE_MONEY_OUT_EN  when defined, adds the change_money output port.
//
// Ports
//   sys_clk        in   system clock
//   sys_rst_n      in   synchronous reset, active-HIGH despite the name
//   sys_Goods      in   add price*quantity to the amount due (SELECT)
//   sys_Confirm    in   start a sale (IDLE) / go to payment (SELECT)
//   sys_Change     in   step CHANGE -> DONE -> IDLE, or REFUND -> IDLE
//   sys_Cancel     in   abort from SELECT or PAY into REFUND
//   in_money_*     in   coin/note strobes worth 1/5/10/20/50 yuan
//   type_SW_high   in   goods-type switch, added to type_SW_low for the price
//   type_SW_low    in   goods-type switch
//   num_SW         in   quantity, 0..3
//   Bit_select     out  digit enable, active-low, one-cold
//   Seg_select     out  segments {dp,g,f,e,d,c,b,a}, active-low
//   need_money     out  amount due, yuan
//   input_money    out  amount paid, yuan
//   state_out      out  one-hot current state
//   change_money   out  change/refund amount (only with CHANGE_MONEY_OUT_EN)
// -----------------------------------------------------------------------------
module state_transitions #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       sys_Goods,
    input  logic       sys_Confirm,
    input  logic       sys_Change,
    input  logic       sys_Cancel,
    input  logic       in_money_one,
    input  logic       in_money_five,
    input  logic       in_money_ten,
    input  logic       in_money_twenty,
    input  logic       in_money_fifty,
    input  logic [2:0] type_SW_high,
    input  logic [2:0] type_SW_low,
    input  logic [1:0] num_SW,
    output logic [7:0] Bit_select,
    output logic [7:0] Seg_select,
    output logic [7:0] need_money,
    output logic [7:0] input_money,
    output logic [5:0] state_out
`ifdef CHANGE_MONEY_OUT_EN
    ,
    output logic [7:0] change_money
`endif
);

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_SELECT = 6'b000010,
        S_PAY    = 6'b000100,
        S_CHANGE = 6'b001000,
        S_DONE   = 6'b010000,
        S_REFUND = 6'b100000
    } state_t;

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t     state;
    state_t     state_next;
    logic [7:0] change_amt;

    // ------------------------------------------------------------------
    // Strobe edge detection: one history register per strobe, so a held
    // button produces a single-cycle pulse in the cycle it first rises.
    // ------------------------------------------------------------------
    logic [8:0] strobe_in;
    logic [8:0] strobe_q;
    logic [8:0] strobe_p;

    assign strobe_in = {in_money_fifty, in_money_twenty, in_money_ten,
                        in_money_five, in_money_one,
                        sys_Cancel, sys_Change, sys_Confirm, sys_Goods};

    // NOTE: reset here is synchronous and active-high even though the port is
    // named sys_rst_n, so it sits inside the clocked branch, not the sensitivity list.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            strobe_q <= '0;
        end else begin
            // NOTE: registers always use non-blocking assignment so every
            // flop samples the pre-edge value of its neighbours.
            strobe_q <= strobe_in;
        end
    end

    assign strobe_p = strobe_in & ~strobe_q;

    logic       goods_p, confirm_p, change_p, cancel_p;
    logic [4:0] coin_p;

    assign goods_p   = strobe_p[0];
    assign confirm_p = strobe_p[1];
    assign change_p  = strobe_p[2];
    assign cancel_p  = strobe_p[3];
    assign coin_p    = strobe_p[8:4];

    // ------------------------------------------------------------------
    // Arithmetic: price, line total, coin total, saturating sums
    // ------------------------------------------------------------------
    logic [3:0] price;
    logic [5:0] goods_amt;
    logic [6:0] coin_sum;
    logic [8:0] need_sum;
    logic [8:0] pay_sum;
    logic       paid_enough;

    assign price     = 4'(type_SW_high) + 4'(type_SW_low);
    assign goods_amt = 6'(price) * 6'(num_SW);
    assign coin_sum  = (coin_p[0] ? 7'd1  : 7'd0) + (coin_p[1] ? 7'd5  : 7'd0)
                     + (coin_p[2] ? 7'd10 : 7'd0) + (coin_p[3] ? 7'd20 : 7'd0)
                     + (coin_p[4] ? 7'd50 : 7'd0);
    assign need_sum    = 9'(need_money) + 9'(goods_amt);
    assign pay_sum     = 9'(input_money) + 9'(coin_sum);
    assign paid_enough = (input_money >= need_money);

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic (Cancel outranks Confirm)
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            S_IDLE:   if (confirm_p) state_next = S_SELECT;
            S_SELECT: begin
                if (cancel_p)                               state_next = S_REFUND;
                else if (confirm_p && (need_money != 8'd0)) state_next = S_PAY;
            end
            S_PAY: begin
                // The comparison uses the registered totals, so CHANGE is
                // entered the cycle after the paid amount reaches the due amount.
                if (cancel_p)         state_next = S_REFUND;
                else if (paid_enough) state_next = S_CHANGE;
            end
            S_CHANGE: if (change_p) state_next = S_DONE;
            S_DONE:   if (change_p) state_next = S_IDLE;
            S_REFUND: if (change_p) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Amount registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            need_money  <= '0;
            input_money <= '0;
            change_amt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Held at zero for the whole idle period, so a finished
                    // sale leaves nothing behind.
                    need_money  <= '0;
                    input_money <= '0;
                    change_amt  <= '0;
                end
                S_SELECT: begin
                    if (cancel_p) begin
                        change_amt <= input_money;
                    end else if (!confirm_p && goods_p) begin
                        need_money <= need_sum[8] ? 8'hFF : need_sum[7:0];
                    end
                end
                S_PAY: begin
                    if (cancel_p) begin
                        change_amt <= input_money;
                    end else if (paid_enough) begin
                        change_amt <= input_money - need_money;
                    end else if (coin_p != '0) begin
                        input_money <= pay_sum[8] ? 8'hFF : pay_sum[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scan counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       scan_idx;

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // FSM process 3: output logic (display content for the current digit)
    // ------------------------------------------------------------------
    logic [7:0] val_a, val_b, disp_val, seg_next;
    logic [3:0] digit;

    always_comb begin
        val_a    = '0;
        val_b    = '0;
        case (state)
            S_SELECT: begin val_a = need_money;  val_b = 8'(goods_amt); end
            S_PAY:    begin val_a = need_money;  val_b = input_money;   end
            S_CHANGE,
            S_DONE:   begin val_a = input_money; val_b = change_amt;    end
            S_REFUND: begin val_a = '0;          val_b = change_amt;    end
            default: ;
        endcase

        disp_val = (scan_idx >= 3'd5) ? val_a : val_b;

        case (scan_idx)
            3'd7, 3'd2: digit = 4'(disp_val / 8'd100);
            3'd6, 3'd1: digit = 4'((disp_val / 8'd10) % 8'd10);
            3'd5, 3'd0: digit = 4'(disp_val % 8'd10);
            default:    digit = '0;
        endcase

        if (state == S_IDLE)                           seg_next = 8'hBF;
        else if (scan_idx == 3'd3 || scan_idx == 3'd4) seg_next = 8'hFF;
        else                                           seg_next = seg_code(digit);
    end

    // Registered display outputs; enable and segments come from the same
    // scan index, so they stay aligned with each other.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            Bit_select <= 8'hFE;
            Seg_select <= 8'hBF;
        end else begin
            Bit_select <= ~(8'h01 << scan_idx);
            Seg_select <= seg_next;
        end
    end

    assign state_out = state;

`ifdef CHANGE_MONEY_OUT_EN
    assign change_money = change_amt;
`endif

endmodule

// File: tb/tb_state_transitions.sv
module tb_state_transitions;

    localparam int SCAN_DIV = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       sys_Goods = 1'b0, sys_Confirm = 1'b0, sys_Change = 1'b0, sys_Cancel = 1'b0;
    logic       in_money_one = 1'b0, in_money_five = 1'b0, in_money_ten = 1'b0;
    logic       in_money_twenty = 1'b0, in_money_fifty = 1'b0;
    logic [2:0] type_SW_high = '0, type_SW_low = '0;
    logic [1:0] num_SW = '0;
    logic [7:0] Bit_select, Seg_select, need_money, input_money;
    logic [5:0] state_out;

    state_transitions #(.SCAN_DIV(SCAN_DIV)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .sys_Goods(sys_Goods), .sys_Confirm(sys_Confirm),
        .sys_Change(sys_Change), .sys_Cancel(sys_Cancel),
        .in_money_one(in_money_one), .in_money_five(in_money_five),
        .in_money_ten(in_money_ten), .in_money_twenty(in_money_twenty),
        .in_money_fifty(in_money_fifty),
        .type_SW_high(type_SW_high), .type_SW_low(type_SW_low), .num_SW(num_SW),
        .Bit_select(Bit_select), .Seg_select(Seg_select),
        .need_money(need_money), .input_money(input_money), .state_out(state_out)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    typedef enum {A_NOP, A_RESET, A_CONFIRM, A_GOODS, A_COIN, A_CHANGE, A_CANCEL} act_e;

    localparam logic [7:0] C1 = 8'd1, C5 = 8'd2, C10 = 8'd4, C20 = 8'd8, C50 = 8'd16;

    function automatic logic [7:0] g(input int hi, input int lo, input int num);
        return 8'((num << 6) | (hi << 3) | lo);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_act(input act_e a, input logic [7:0] arg);
        case (a)
            A_RESET: begin
                sys_rst_n = 1'b1; tick(); tick();
                sys_rst_n = 1'b0; tick();
            end
            A_CONFIRM: begin sys_Confirm = 1'b1; tick(); sys_Confirm = 1'b0; tick(); tick(); end
            A_CHANGE:  begin sys_Change  = 1'b1; tick(); sys_Change  = 1'b0; tick(); tick(); end
            A_CANCEL:  begin sys_Cancel  = 1'b1; tick(); sys_Cancel  = 1'b0; tick(); tick(); end
            A_GOODS: begin
                type_SW_low  = arg[2:0];
                type_SW_high = arg[5:3];
                num_SW       = arg[7:6];
                sys_Goods = 1'b1; tick(); sys_Goods = 1'b0; tick(); tick();
            end
            A_COIN: begin
                in_money_one = arg[0]; in_money_five = arg[1]; in_money_ten = arg[2];
                in_money_twenty = arg[3]; in_money_fifty = arg[4];
                tick();
                {in_money_fifty, in_money_twenty, in_money_ten, in_money_five, in_money_one} = '0;
                tick(); tick();
            end
            default: ;
        endcase
    endtask

    // Waits (bounded) until digit d is enabled and returns its segments.
    task automatic read_digit(input int d, output logic [7:0] seg);
        logic [7:0] sel;
        bit found;
        sel = ~(8'h01 << d);
        found = 0;
        seg = 8'h00;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge sys_clk);
            if (Bit_select === sel) begin
                seg = Seg_select;
                found = 1;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL digit%0d_timeout: got Bit_select 0x%0h expected 0x%0h", d, Bit_select, sel);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_SELECT, P_PAY, P_CHANGE, P_DONE, P_REFUND} phase_t;
    phase_t m_phase;
    int m_need, m_inp, m_chg;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [5:0] onehot(input phase_t p);
        case (p)
            P_IDLE:   return 6'b000001;
            P_SELECT: return 6'b000010;
            P_PAY:    return 6'b000100;
            P_CHANGE: return 6'b001000;
            P_DONE:   return 6'b010000;
            default:  return 6'b100000;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_idle();
        m_phase = P_IDLE; m_need = 0; m_inp = 0; m_chg = 0;
    endtask

    task automatic model_step(input act_e a, input logic [7:0] arg);
        int coins;
        case (a)
            A_RESET: model_idle();
            A_CONFIRM: begin
                if (m_phase == P_IDLE) begin model_idle(); m_phase = P_SELECT; end
                else if (m_phase == P_SELECT && m_need > 0) m_phase = P_PAY;
            end
            A_GOODS: if (m_phase == P_SELECT)
                m_need = sat(m_need + (int'(arg[5:3]) + int'(arg[2:0])) * int'(arg[7:6]));
            A_CHANGE: begin
                if (m_phase == P_CHANGE) m_phase = P_DONE;
                else if (m_phase == P_DONE || m_phase == P_REFUND) model_idle();
            end
            A_CANCEL: if (m_phase == P_SELECT || m_phase == P_PAY) begin
                m_phase = P_REFUND; m_chg = m_inp;
            end
            A_COIN: if (m_phase == P_PAY) begin
                coins = (arg[0] ? 1 : 0) + (arg[1] ? 5 : 0) + (arg[2] ? 10 : 0)
                      + (arg[3] ? 20 : 0) + (arg[4] ? 50 : 0);
                m_inp = sat(m_inp + coins);
                if (m_inp >= m_need) begin m_phase = P_CHANGE; m_chg = m_inp - m_need; end
            end
            default: ;
        endcase
    endtask

    function automatic logic [7:0] exp_seg(input int d);
        int a, b, v, p;
        if (m_phase == P_IDLE) return 8'hBF;
        if (d == 3 || d == 4) return 8'hFF;
        case (m_phase)
            P_SELECT: begin a = m_need; b = (int'(type_SW_high) + int'(type_SW_low)) * int'(num_SW); end
            P_PAY:    begin a = m_need; b = m_inp; end
            P_REFUND: begin a = 0;      b = m_chg; end
            default:  begin a = m_inp;  b = m_chg; end
        endcase
        v = (d >= 5) ? a : b;
        p = (d >= 5) ? d - 5 : d;
        if (p == 0) return seg_tab[v % 10];
        if (p == 1) return seg_tab[(v / 10) % 10];
        return seg_tab[v / 100];
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        act_e       act;
        logic [7:0] arg;
        logic [5:0] st;
        int         need;
        int         inp;
        int         dig;   // -1: no display check
        logic [7:0] seg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(act_e a, logic [7:0] arg, logic [5:0] st, int need, int inp,
                                int dig, logic [7:0] seg);
        vec_t v;
        v.act = a; v.arg = arg; v.st = st; v.need = need; v.inp = inp; v.dig = dig; v.seg = seg;
        return v;
    endfunction

    initial begin
        logic [7:0] seg;
        logic [7:0] exp_bit;
        int         r;
        act_e       a;
        logic [7:0] arg;

        // Reset values while reset is held
        sys_rst_n = 1'b1;
        tick(); tick(); tick();
        check("rst_state", state_out, 6'b000001);
        check("rst_need", need_money, 0);
        check("rst_input", input_money, 0);
        check("rst_bit", Bit_select, 8'hFE);
        check("rst_seg", Seg_select, 8'hBF);

        tbl.push_back(mk(A_RESET,   0,          6'b000001, 0,  0,  0, 8'hBF));
        tbl.push_back(mk(A_CONFIRM, 0,          6'b000010, 0,  0, -1, 0));
        tbl.push_back(mk(A_CONFIRM, 0,          6'b000010, 0,  0, -1, 0));
        tbl.push_back(mk(A_GOODS,   g(5, 2, 0), 6'b000010, 0,  0,  0, 8'hC0));
        tbl.push_back(mk(A_COIN,    8'h1F,      6'b000010, 0,  0, -1, 0));
        tbl.push_back(mk(A_GOODS,   g(2, 1, 3), 6'b000010, 9,  0,  0, 8'h90));
        tbl.push_back(mk(A_GOODS,   g(3, 3, 1), 6'b000010, 15, 0,  6, 8'hF9));
        tbl.push_back(mk(A_CONFIRM, 0,          6'b000100, 15, 0, -1, 0));
        tbl.push_back(mk(A_COIN,    C1,         6'b000100, 15, 1, -1, 0));
        tbl.push_back(mk(A_COIN,    C5,         6'b000100, 15, 6,  7, 8'hC0));
        tbl.push_back(mk(A_NOP,     0,          6'b000100, 15, 6,  5, 8'h92));
        tbl.push_back(mk(A_NOP,     0,          6'b000100, 15, 6,  0, 8'h82));
        tbl.push_back(mk(A_NOP,     0,          6'b000100, 15, 6,  4, 8'hFF));
        tbl.push_back(mk(A_GOODS,   g(1, 1, 1), 6'b000100, 15, 6, -1, 0));
        tbl.push_back(mk(A_CONFIRM, 0,          6'b000100, 15, 6, -1, 0));
        tbl.push_back(mk(A_COIN,    C10,        6'b001000, 15, 16, 0, 8'hF9));
        tbl.push_back(mk(A_NOP,     0,          6'b001000, 15, 16, 5, 8'h82));
        tbl.push_back(mk(A_COIN,    C20,        6'b001000, 15, 16, -1, 0));
        tbl.push_back(mk(A_COIN,    C50,        6'b001000, 15, 16, -1, 0));
        tbl.push_back(mk(A_CANCEL,  0,          6'b001000, 15, 16, -1, 0));
        tbl.push_back(mk(A_CHANGE,  0,          6'b010000, 15, 16, 0, 8'hF9));
        tbl.push_back(mk(A_CHANGE,  0,          6'b000001, 0,  0,  3, 8'hBF));
        tbl.push_back(mk(A_CHANGE,  0,          6'b000001, 0,  0, -1, 0));
        tbl.push_back(mk(A_CONFIRM, 0,          6'b000010, 0,  0, -1, 0));
        tbl.push_back(mk(A_GOODS,   g(3, 3, 3), 6'b000010, 18, 0, -1, 0));
        tbl.push_back(mk(A_CONFIRM, 0,          6'b000100, 18, 0, -1, 0));
        tbl.push_back(mk(A_COIN,    C1 | C5,    6'b000100, 18, 6, -1, 0));
        tbl.push_back(mk(A_CANCEL,  0,          6'b100000, 18, 6,  0, 8'h82));
        tbl.push_back(mk(A_NOP,     0,          6'b100000, 18, 6,  7, 8'hC0));
        tbl.push_back(mk(A_CHANGE,  0,          6'b000001, 0,  0, -1, 0));

        foreach (tbl[i]) begin
            do_act(tbl[i].act, tbl[i].arg);
            check($sformatf("vec%0d_state", i), state_out, tbl[i].st);
            check($sformatf("vec%0d_need", i), need_money, tbl[i].need);
            check($sformatf("vec%0d_input", i), input_money, tbl[i].inp);
            if (tbl[i].dig >= 0) begin
                read_digit(tbl[i].dig, seg);
                check($sformatf("vec%0d_digit%0d", i, tbl[i].dig), seg, tbl[i].seg);
            end
        end

        // Held Goods acts once; then saturation of need and of input
        do_act(A_CONFIRM, 0);
        type_SW_high = 3'd7; type_SW_low = 3'd7; num_SW = 2'd3;
        sys_Goods = 1'b1;
        repeat (5) tick();
        sys_Goods = 1'b0;
        tick(); tick();
        check("held_goods_once", need_money, 42);
        repeat (6) do_act(A_GOODS, g(7, 7, 3));
        check("need_saturate", need_money, 255);
        do_act(A_CONFIRM, 0);
        repeat (5) do_act(A_COIN, C50);
        check("pay_250_state", state_out, 6'b000100);
        check("pay_250_input", input_money, 250);
        do_act(A_COIN, C50);
        check("input_saturate", input_money, 255);
        check("sat_change_state", state_out, 6'b001000);
        read_digit(0, seg);
        check("sat_change_zero", seg, 8'hC0);
        read_digit(7, seg);
        check("sat_input_hundreds", seg, 8'hA4);

        // Reset during payment discards everything, no refund
        do_act(A_CHANGE, 0);
        do_act(A_CHANGE, 0);
        do_act(A_CONFIRM, 0);
        do_act(A_GOODS, g(3, 3, 3));
        do_act(A_CONFIRM, 0);
        do_act(A_COIN, C1);
        check("midpay_input", input_money, 1);
        sys_rst_n = 1'b1;
        tick(); tick();
        check("midpay_rst_state", state_out, 6'b000001);
        check("midpay_rst_need", need_money, 0);
        check("midpay_rst_input", input_money, 0);
        sys_rst_n = 1'b0;
        tick(); tick();
        check("midpay_after_state", state_out, 6'b000001);

        // Digit scan: steps every SCAN_DIV cycles, wraps 7F -> FE
        do_act(A_RESET, 0);
        for (int i = 0; i < 40 && Bit_select === 8'hFE; i++) tick();
        for (int j = 0; j < 36; j++) begin
            exp_bit = ~(8'h01 << ((1 + j / SCAN_DIV) % 8));
            check($sformatf("scan_%0d", j), Bit_select, exp_bit);
            tick();
        end

        // Randomized events against the reference model
        do_act(A_RESET, 0);
        model_step(A_RESET, 0);
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 15));
            arg = '0;
            if (r < 3)       a = A_CONFIRM;
            else if (r < 6)  begin a = A_GOODS; arg = 8'($urandom_range(0, 255)); end
            else if (r < 8)  a = A_CHANGE;
            else if (r < 15) begin a = A_COIN; arg = 8'($urandom_range(1, 31)); end
            else             a = A_CANCEL;
            do_act(a, arg);
            model_step(a, arg);
            check($sformatf("rnd%0d_state", k), state_out, onehot(m_phase));
            check($sformatf("rnd%0d_need", k), need_money, m_need);
            check($sformatf("rnd%0d_input", k), input_money, m_inp);
            if (k % 25 == 24) begin
                r = int'($urandom_range(0, 7));
                read_digit(r, seg);
                check($sformatf("rnd%0d_digit%0d", k, r), seg, exp_seg(r));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
